// File: rtl/pulse_meter.sv
// Measures high time and period of an asynchronous input in prescaled time units.
// Result handshake: result is transferred in any cycle where out_valid && out_ready; outputs hold until then.
module pulse_meter #(
    parameter int CLK_PER_UNIT  = 50000,
    parameter int TIMEOUT_UNITS = 1000,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic             start,
    input  logic             out_ready,
    output logic             busy,
    output logic             out_valid,
    output logic [CNT_W-1:0] high_time,
    output logic [CNT_W-1:0] period,
    output logic             timeout,
    output logic [2:0]       state_dbg
);
    localparam int PW = $clog2(CLK_PER_UNIT);
    localparam logic [PW-1:0]    PRESC_MAX = PW'(CLK_PER_UNIT - 1);
    localparam logic [CNT_W-1:0] TO_UNITS  = CNT_W'(TIMEOUT_UNITS);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARM  = 3'd1,
        HIGH = 3'd2,
        LOW  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t           state, state_nxt;
    logic             sync1, sync2, hist;
    logic [PW-1:0]    presc, presc_nxt;
    logic [CNT_W-1:0] elapsed, elapsed_nxt, elapsed_tick;
    logic [CNT_W-1:0] high_time_nxt, period_nxt;
    logic             timeout_nxt;
    logic             rise, fall, tick, expired;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            hist  <= 1'b0;
        end else begin
            sync1 <= sig_in;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    assign rise    = sync2 & ~hist;
    assign fall    = ~sync2 & hist;
    assign tick    = (presc == PRESC_MAX);
    assign expired = (elapsed == TO_UNITS);
    // Elapsed saturates at the timeout value, so it can never wrap.
    assign elapsed_tick = (tick && !expired) ? elapsed + CNT_W'(1) : elapsed;

    always_comb begin
        state_nxt     = state;
        presc_nxt     = presc;
        elapsed_nxt   = elapsed;
        high_time_nxt = high_time;
        period_nxt    = period;
        timeout_nxt   = timeout;

        if (state == ARM || state == HIGH || state == LOW) begin
            presc_nxt   = tick ? '0 : presc + PW'(1);
            elapsed_nxt = elapsed_tick;
        end

        // Timeout is tested before edges so it wins a same-cycle tie.
        case (state)
            IDLE: begin
                presc_nxt   = '0;
                elapsed_nxt = '0;
                if (start) state_nxt = ARM;
            end
            ARM: begin
                if (expired) begin
                    state_nxt     = DONE;
                    high_time_nxt = '0;
                    period_nxt    = '0;
                    timeout_nxt   = 1'b1;
                end else if (rise) begin
                    state_nxt   = HIGH;
                    presc_nxt   = '0;
                    elapsed_nxt = '0;
                end
            end
            HIGH: begin
                if (expired) begin
                    state_nxt     = DONE;
                    high_time_nxt = TO_UNITS;
                    period_nxt    = TO_UNITS;
                    timeout_nxt   = 1'b1;
                end else if (fall) begin
                    state_nxt     = LOW;
                    high_time_nxt = elapsed_tick;
                end
            end
            LOW: begin
                if (expired) begin
                    state_nxt   = DONE;
                    period_nxt  = TO_UNITS;
                    timeout_nxt = 1'b1;
                end else if (rise) begin
                    state_nxt   = DONE;
                    period_nxt  = elapsed_tick;
                    timeout_nxt = 1'b0;
                end
            end
            DONE: begin
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            presc     <= '0;
            elapsed   <= '0;
            high_time <= '0;
            period    <= '0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_nxt;
            presc     <= presc_nxt;
            elapsed   <= elapsed_nxt;
            high_time <= high_time_nxt;
            period    <= period_nxt;
            timeout   <= timeout_nxt;
        end
    end

    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);
    assign state_dbg = state;

endmodule

// File: tb/tb_pulse_meter.sv
// Bench for pulse_meter: directed scenarios plus random waveforms against an edge-time reference model.
module tb_pulse_meter;
    localparam int CPU = 10;
    localparam int TOU = 20;
    localparam int W   = 8;
    localparam int EW  = 2 * W + 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         sig_in = 1'b0;
    logic         start = 1'b0;
    logic         out_ready = 1'b0;
    logic         busy, out_valid, timeout;
    logic [W-1:0] high_time, period;
    logic [2:0]   state_dbg;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int valid_cyc = -1;
    logic mon_arm = 1'b0;

    int rise_q[$], fall_q[$];
    int seg_lvl[$], seg_len[$], extra_start[$];
    logic [EW-1:0] exp_q[$];
    int s_cyc, exp_done;
    logic [W-1:0] obs_ht, obs_per;
    logic obs_to;

    pulse_meter #(.CLK_PER_UNIT(CPU), .TIMEOUT_UNITS(TOU), .CNT_W(W)) dut (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .start(start), .out_ready(out_ready),
        .busy(busy), .out_valid(out_valid), .high_time(high_time), .period(period),
        .timeout(timeout), .state_dbg(state_dbg)
    );

    // clock / cycle counter / first-valid monitor
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (!mon_arm) valid_cyc <= -1;
        else if (out_valid && valid_cyc < 0) valid_cyc <= cyc;
    end

    // Drive sig_in at a negedge; the edge is seen as rise/fall in cycle cyc+2.
    task automatic set_sig(input logic v);
        if (v !== sig_in) begin
            if (v) rise_q.push_back(cyc + 2);
            else   fall_q.push_back(cyc + 2);
        end
        sig_in = v;
    endtask

    task automatic run_meas(input logic pre);
        int  t;
        logic hit;
        mon_arm = 1'b0;
        @(negedge clk);
        set_sig(pre);
        repeat (4) @(negedge clk);
        rise_q.delete();
        fall_q.delete();
        mon_arm = 1'b1;
        t = 0;
        for (int i = 0; i < seg_lvl.size(); i++) begin
            for (int j = 0; j < seg_len[i]; j++) begin
                @(negedge clk);
                if (t == 0) s_cyc = cyc;
                hit = (t == 0);
                foreach (extra_start[k]) if (extra_start[k] == t) hit = 1'b1;
                start = hit;
                set_sig(seg_lvl[i] != 0);
                t++;
            end
        end
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 1000 && !out_valid; k++) @(negedge clk);
        #1;
        obs_ht  = high_time;
        obs_per = period;
        obs_to  = timeout;
    endtask

    task automatic accept(input logic st);
        @(negedge clk);
        out_ready = 1'b1;
        start = st;
        @(negedge clk);
        out_ready = 1'b0;
        start = 1'b0;
    endtask

    // Reference: rules on detected edge times, result packed as {timeout, period, high_time}.
    task automatic model(output logic [EW-1:0] e, output int done);
        int a, lim, r, f, r2;
        a = s_cyc + 1;
        lim = TOU * CPU;
        r = -1; f = -1; r2 = -1;
        foreach (rise_q[i]) if (r < 0 && rise_q[i] >= a) r = rise_q[i];
        if (r < 0 || r > a + lim - 1) begin
            e = {1'b1, W'(0), W'(0)}; done = a + lim + 1; return;
        end
        foreach (fall_q[i]) if (f < 0 && fall_q[i] > r) f = fall_q[i];
        if (f < 0 || f - r > lim) begin
            e = {1'b1, W'(TOU), W'(TOU)}; done = r + lim + 2; return;
        end
        foreach (rise_q[i]) if (r2 < 0 && rise_q[i] > f) r2 = rise_q[i];
        if (r2 < 0 || r2 - r > lim) begin
            e = {1'b1, W'(TOU), W'((f - r) / CPU)}; done = r + lim + 2; return;
        end
        e = {1'b0, W'((r2 - r) / CPU), W'((f - r) / CPU)};
        done = r2 + 1;
    endtask

    task automatic load_spec_pattern();
        seg_lvl = '{0, 1, 0, 1};
        seg_len = '{5, 35, 45, 40};
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, out_valid, timeout, high_time, period} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got busy=%0b valid=%0b to=%0b ht=%0d per=%0d exp all 0",
                     busy, out_valid, timeout, high_time, period);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle got busy=%0b exp 0", busy);
        end
    endtask

    task automatic test_spec_example();
        logic [EW-1:0] e;
        extra_start.delete();
        load_spec_pattern();
        run_meas(1'b0);
        model(e, exp_done);
        exp_q.push_back(e);
        checks++;
        if ({obs_to, obs_per, obs_ht} !== {1'b0, W'(8), W'(3)}) begin
            failures++;
            $display("FAIL spec_result got to=%0d per=%0d ht=%0d exp to=0 per=8 ht=3", obs_to, obs_per, obs_ht);
        end
        e = exp_q.pop_front();
        checks++;
        if (valid_cyc !== exp_done || {obs_to, obs_per, obs_ht} !== e) begin
            failures++;
            $display("FAIL spec_model got cyc=%0d res=%h exp cyc=%0d res=%h", valid_cyc, {obs_to, obs_per, obs_ht}, exp_done, e);
        end
        accept(1'b0);
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL spec_accept got busy=%0b valid=%0b exp 0 0", busy, out_valid);
        end
    endtask

    task automatic test_arm_timeout();
        extra_start.delete();
        seg_lvl = '{0};
        seg_len = '{250};
        run_meas(1'b0);
        checks++;
        if ({obs_to, obs_per, obs_ht} !== {1'b1, W'(0), W'(0)}) begin
            failures++;
            $display("FAIL arm_timeout_result got to=%0d per=%0d ht=%0d exp to=1 per=0 ht=0", obs_to, obs_per, obs_ht);
        end
        checks++;
        if (valid_cyc - s_cyc !== 202) begin
            failures++;
            $display("FAIL arm_timeout_latency got %0d exp 202", valid_cyc - s_cyc);
        end
        accept(1'b0);
    endtask

    task automatic test_high_timeout();
        extra_start.delete();
        seg_lvl = '{0, 1};
        seg_len = '{5, 300};
        run_meas(1'b0);
        checks++;
        if ({obs_to, obs_per, obs_ht} !== {1'b1, W'(TOU), W'(TOU)}) begin
            failures++;
            $display("FAIL high_timeout_result got to=%0d per=%0d ht=%0d exp to=1 per=20 ht=20", obs_to, obs_per, obs_ht);
        end
        accept(1'b0);
    endtask

    task automatic test_hold();
        int bad;
        extra_start.delete();
        load_spec_pattern();
        run_meas(1'b0);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            sig_in = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if (out_valid !== 1'b1 || {timeout, period, high_time} !== {1'b0, W'(8), W'(3)}) begin
                failures++;
                if (bad == 0)
                    $display("FAIL hold_stable got valid=%0b to=%0d per=%0d ht=%0d exp 1 0 8 3", out_valid, timeout, period, high_time);
                bad++;
            end
        end
        accept(1'b0);
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL hold_accept got busy=%0b valid=%0b exp 0 0", busy, out_valid);
        end
        @(negedge clk);
        sig_in = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        sig_in = 1'b1;
        repeat (15) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_busy got %0b exp 1", busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, out_valid, timeout, high_time, period} !== '0) begin
            failures++;
            $display("FAIL reset_mid_outputs got busy=%0b valid=%0b to=%0b ht=%0d per=%0d exp all 0",
                     busy, out_valid, timeout, high_time, period);
        end
        sig_in = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_idle got busy=%0b exp 0", busy);
        end
        extra_start.delete();
        load_spec_pattern();
        run_meas(1'b0);
        checks++;
        if ({obs_to, obs_per, obs_ht} !== {1'b0, W'(8), W'(3)}) begin
            failures++;
            $display("FAIL reset_mid_fresh got to=%0d per=%0d ht=%0d exp to=0 per=8 ht=3", obs_to, obs_per, obs_ht);
        end
        accept(1'b0);
    endtask

    task automatic test_start_ignored();
        logic [EW-1:0] e;
        extra_start = '{20, 110};
        load_spec_pattern();
        run_meas(1'b0);
        model(e, exp_done);
        checks++;
        if ({obs_to, obs_per, obs_ht} !== {1'b0, W'(8), W'(3)} || valid_cyc !== exp_done) begin
            failures++;
            $display("FAIL start_ignored_result got to=%0d per=%0d ht=%0d cyc=%0d exp 0 8 3 cyc=%0d",
                     obs_to, obs_per, obs_ht, valid_cyc, exp_done);
        end
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1 || {timeout, period, high_time} !== {1'b0, W'(8), W'(3)}) begin
            failures++;
            $display("FAIL start_in_done got valid=%0b to=%0d per=%0d ht=%0d exp 1 0 8 3", out_valid, timeout, period, high_time);
        end
        accept(1'b1);
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL start_in_accept got busy=%0b exp 0", busy);
        end
        extra_start.delete();
    endtask

    task automatic test_boundary();
        logic [EW-1:0] e;
        int lens[3] = '{199, 200, 201};
        for (int i = 0; i < 3; i++) begin
            seg_lvl = '{0, 1, 0};
            seg_len = '{3, lens[i], 260};
            run_meas(1'b0);
            model(e, exp_done);
            checks++;
            if ({obs_to, obs_per, obs_ht} !== e || valid_cyc !== exp_done) begin
                failures++;
                $display("FAIL boundary_high%0d got res=%h cyc=%0d exp res=%h cyc=%0d",
                         lens[i], {obs_to, obs_per, obs_ht}, valid_cyc, e, exp_done);
            end
            accept(1'b0);
        end
    endtask

    task automatic test_random();
        logic [EW-1:0] e;
        logic pre;
        int lvl, n;
        for (int it = 0; it < 25; it++) begin
            seg_lvl.delete();
            seg_len.delete();
            pre = 1'($urandom_range(0, 1));
            lvl = $urandom_range(0, 1);
            n = $urandom_range(2, 6);
            for (int i = 0; i < n; i++) begin
                seg_lvl.push_back(lvl);
                seg_len.push_back(($urandom_range(0, 5) == 0) ? $urandom_range(150, 260) : $urandom_range(1, 60));
                lvl = 1 - lvl;
            end
            run_meas(pre);
            model(e, exp_done);
            exp_q.push_back(e);
            e = exp_q.pop_front();
            checks++;
            if ({obs_to, obs_per, obs_ht} !== e) begin
                failures++;
                $display("FAIL random_result[%0d] got to=%0d per=%0d ht=%0d exp to=%0d per=%0d ht=%0d",
                         it, obs_to, obs_per, obs_ht, e[EW-1], e[2*W-1:W], e[W-1:0]);
            end
            checks++;
            if (valid_cyc !== exp_done) begin
                failures++;
                $display("FAIL random_latency[%0d] got cyc=%0d exp cyc=%0d", it, valid_cyc, exp_done);
            end
            accept(1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_spec_example();
        test_arm_timeout();
        test_high_timeout();
        test_hold();
        test_reset_mid();
        test_start_ignored();
        test_boundary();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pulse_meter.md
PULSE_METER -- requirements
Module: pulse_meter

Interface
REQ-001 SHALL have parameter CLK_PER_UNIT, default 50000, clk cycles per measurement unit (1 ms at 50 MHz); legal range 2 or more.
REQ-002 SHALL have parameter TIMEOUT_UNITS, default 1000, units after which a measurement aborts; legal range 1 to 2^CNT_W-1.
REQ-003 SHALL have parameter CNT_W, default 16, width of the unit counters and results.
REQ-004 clk  input  1  system clock, 50 MHz, all logic on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 sig_in  input  1  measured signal, asynchronous to clk.
REQ-007 start  input  1  one-cycle request to begin a measurement.
REQ-008 out_ready  input  1  consumer accepts result.
REQ-009 busy  output  1  high in any state other than IDLE.
REQ-010 out_valid  output  1  result available.
REQ-011 high_time  output  CNT_W  units from detected rise to detected fall.
REQ-012 period  output  CNT_W  units from detected rise to next detected rise.
REQ-013 timeout  output  1  result aborted by timeout; qualified by out_valid.

Function
REQ-014 sig_in SHALL pass through a 2-flop synchronizer followed by one history flop; rise = sync & ~hist; fall = ~sync & hist.
REQ-015 States SHALL be IDLE, ARM, HIGH, LOW, DONE.
REQ-016 IDLE: start=1 -> ARM next cycle. Prescaler and elapsed SHALL clear. start SHALL be ignored in all other states.
REQ-017 ARM: rise -> HIGH. If sig_in is already high at start, the block SHALL wait for a fresh rising edge.
REQ-018 Prescaler SHALL count 0..CLK_PER_UNIT-1 and wrap. tick SHALL assert in the cycle the prescaler equals CLK_PER_UNIT-1. On tick, elapsed SHALL increment by 1.
REQ-019 On rise in ARM, prescaler and elapsed SHALL clear to 0 in that cycle, so the next tick occurs CLK_PER_UNIT cycles later.
REQ-020 HIGH: fall -> LOW, and high_time register SHALL take the value of elapsed including any tick in the same cycle.
REQ-021 LOW: rise -> DONE, period register SHALL take the value of elapsed including any tick in the same cycle, and timeout SHALL be 0.
REQ-022 Result encoding: high_time = floor(N_high / CLK_PER_UNIT) and period = floor(N_per / CLK_PER_UNIT), where N_high and N_per are clk counts between the detected edges.
REQ-023 Timeout SHALL occur when elapsed reaches TIMEOUT_UNITS in ARM, HIGH or LOW. On timeout the block SHALL go to DONE with timeout=1 and the following results:
  - ARM: high_time=0, period=0.
  - HIGH: high_time=period=TIMEOUT_UNITS.
  - LOW: high_time keeps its latched value, period=TIMEOUT_UNITS.
REQ-024 Timeout and an edge in the same cycle: timeout SHALL win.
REQ-025 DONE: out_valid=1. high_time, period and timeout SHALL be held stable while out_valid=1 and out_ready=0.
REQ-026 out_valid & out_ready -> IDLE next cycle; out_valid deasserts that next cycle. A start asserted in the accept cycle SHALL be ignored.
REQ-027 Elapsed SHALL never exceed TIMEOUT_UNITS; no wrap-around is possible.
REQ-028 Edge detection latency: a sig_in transition SHALL be seen as rise or fall 2-3 clk after it occurs. The state changes on the following clock edge.

Reset
REQ-029 rst_n low SHALL asynchronously force state=IDLE, with synchronizer and history flops=0, prescaler=0, elapsed=0.
REQ-030 rst_n low SHALL force busy=0, out_valid=0, timeout=0, high_time=0, period=0.
REQ-031 Reset asserted mid-measurement SHALL abort with no result. After release, the block SHALL wait in IDLE for start.

Verification (CLK_PER_UNIT=10, TIMEOUT_UNITS=20, CNT_W=8)
REQ-032 start; sig_in low 5 clk, high 35 clk, low 45 clk, then high -> out_valid=1, high_time=3, period=8, timeout=0.
REQ-033 start with sig_in held low for 250 clk -> out_valid with timeout=1, high_time=0, period=0, exactly 200 clk after ARM entry plus the 1 cycle to DONE.
REQ-034 start; rise, then sig_in held high for 300 clk -> timeout=1, high_time=20, period=20.
REQ-035 Completed measurement with out_ready=0 for 50 clk while sig_in toggles -> outputs unchanged and out_valid held. Then out_ready=1 for 1 clk -> IDLE, busy=0.
REQ-036 rst_n pulsed low during HIGH -> all outputs 0 immediately. A later start gives a correct fresh measurement per REQ-032.
REQ-037 start pulsed during HIGH and during DONE -> no effect on state or results.
